// File: rtl/rs_issue_queue.sv
// Unified reservation station: dual-lane dispatch, CDB wakeup with dispatch bypass,
// and age-matrix oldest-ready select to ALU0, ALU1 and MEM.
module rs_issue_queue #(
    parameter int N_ENT  = 16,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int PAY_W  = 64,
    parameter int N_CDB  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [1:0]                       disp_valid,
    input  logic [1:0][1:0]                  disp_fu,
    input  logic [1:0][PREG_W-1:0]           disp_src1_tag,
    input  logic [1:0][PREG_W-1:0]           disp_src2_tag,
    input  logic [1:0]                       disp_src1_rdy,
    input  logic [1:0]                       disp_src2_rdy,
    input  logic [1:0][XLEN-1:0]             disp_src1_val,
    input  logic [1:0][XLEN-1:0]             disp_src2_val,
    input  logic [1:0][ROB_W-1:0]            disp_rob,
    input  logic [1:0][PAY_W-1:0]            disp_payload,
    output logic                             rs_stall,
    output logic                             rs_overflow,
    input  logic [N_CDB-1:0]                 cdb_valid,
    input  logic [N_CDB-1:0][PREG_W-1:0]     cdb_tag,
    input  logic [N_CDB-1:0][XLEN-1:0]       cdb_value,
    input  logic [2:0]                       fu_stall,
    output logic [2:0]                       iss_valid,
    output logic [2:0][XLEN-1:0]             iss_src1_val,
    output logic [2:0][XLEN-1:0]             iss_src2_val,
    output logic [2:0][ROB_W-1:0]            iss_rob,
    output logic [2:0][PAY_W-1:0]            iss_payload
);

    localparam int IDX_W = $clog2(N_ENT);
    localparam int CNT_W = $clog2(N_ENT + 1);

    logic [N_ENT-1:0]                   valid_q, valid_d;
    logic [N_ENT-1:0][1:0]              fu_q, fu_d;
    logic [N_ENT-1:0][1:0][PREG_W-1:0]  tag_q, tag_d;
    logic [N_ENT-1:0][1:0]              rdy_q, rdy_d;
    logic [N_ENT-1:0][1:0][XLEN-1:0]    val_q, val_d;
    logic [N_ENT-1:0][ROB_W-1:0]        rob_q, rob_d;
    logic [N_ENT-1:0][PAY_W-1:0]        pay_q, pay_d;
    logic [N_ENT-1:0][N_ENT-1:0]        age_q, age_d;
    logic                               rs_overflow_q, rs_overflow_d;

    logic [1:0][1:0][PREG_W-1:0]        ln_tag;
    logic [1:0][1:0]                    ln_rdy;
    logic [1:0][1:0][XLEN-1:0]          ln_val;
    logic                               byp_hit;
    logic [XLEN-1:0]                    byp_val;
    logic                               wk_hit;
    logic [XLEN-1:0]                    wk_val;

    logic [CNT_W-1:0]                   free_cnt;
    logic [IDX_W-1:0]                   first_free, second_free;
    logic [1:0][IDX_W-1:0]              lane_idx;
    logic [1:0]                         wr_lane;

    logic [2:0][N_ENT-1:0]              cand;
    logic                               older_found;
    logic [N_ENT-1:0]                   issued;

    // Dispatch lanes with same-cycle CDB bypass; descending scan so the lowest port wins.
    always_comb begin
        ln_tag  = '0;
        ln_rdy  = '0;
        ln_val  = '0;
        byp_hit = 1'b0;
        byp_val = '0;
        for (int l = 0; l < 2; l++) begin
            ln_tag[l][0] = disp_src1_tag[l];
            ln_tag[l][1] = disp_src2_tag[l];
            ln_rdy[l][0] = disp_src1_rdy[l];
            ln_rdy[l][1] = disp_src2_rdy[l];
            ln_val[l][0] = disp_src1_val[l];
            ln_val[l][1] = disp_src2_val[l];
            for (int s = 0; s < 2; s++) begin
                byp_hit = 1'b0;
                byp_val = '0;
                for (int k = N_CDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && cdb_tag[k] == ln_tag[l][s]) begin
                        byp_hit = 1'b1;
                        byp_val = cdb_value[k];
                    end
                end
                if (!ln_rdy[l][s] && byp_hit) begin
                    ln_rdy[l][s] = 1'b1;
                    ln_val[l][s] = byp_val;
                end
            end
        end
    end

    always_comb begin
        free_cnt    = '0;
        first_free  = '0;
        second_free = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (!valid_q[i]) begin
                if (free_cnt == '0)
                    first_free = IDX_W'(i);
                else if (free_cnt == CNT_W'(1))
                    second_free = IDX_W'(i);
                free_cnt = free_cnt + CNT_W'(1);
            end
        end
    end

    assign rs_stall    = free_cnt < CNT_W'(2);
    assign rs_overflow = rs_overflow_q;

    always_comb begin
        lane_idx[0] = first_free;
        lane_idx[1] = disp_valid[0] ? second_free : first_free;
        for (int l = 0; l < 2; l++)
            wr_lane[l] = disp_valid[l] && !rs_stall && !flush && (disp_fu[l] != 2'd3);
        rs_overflow_d = rs_overflow_q;
        if (!flush) begin
            if (rs_stall && (|disp_valid))
                rs_overflow_d = 1'b1;
            if (!rs_stall && ((disp_valid[0] && disp_fu[0] == 2'd3) ||
                              (disp_valid[1] && disp_fu[1] == 2'd3)))
                rs_overflow_d = 1'b1;
        end
    end

    // A candidate is the oldest if no other candidate for the same FU is older than it.
    always_comb begin
        cand         = '0;
        older_found  = 1'b0;
        issued       = '0;
        iss_valid    = '0;
        iss_src1_val = '0;
        iss_src2_val = '0;
        iss_rob      = '0;
        iss_payload  = '0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N_ENT; i++)
                cand[f][i] = valid_q[i] && (fu_q[i] == 2'(f)) && (&rdy_q[i]);
            for (int i = 0; i < N_ENT; i++) begin
                older_found = 1'b0;
                for (int j = 0; j < N_ENT; j++)
                    if (cand[f][j] && age_q[j][i])
                        older_found = 1'b1;
                if (cand[f][i] && !older_found && !fu_stall[f]) begin
                    iss_valid[f]    = 1'b1;
                    issued[i]       = 1'b1;
                    iss_src1_val[f] = val_q[i][0];
                    iss_src2_val[f] = val_q[i][1];
                    iss_rob[f]      = rob_q[i];
                    iss_payload[f]  = pay_q[i];
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q & ~issued;
        fu_d    = fu_q;
        tag_d   = tag_q;
        rdy_d   = rdy_q;
        val_d   = val_q;
        rob_d   = rob_q;
        pay_d   = pay_q;
        age_d   = age_q;
        wk_hit  = 1'b0;
        wk_val  = '0;
        for (int i = 0; i < N_ENT; i++) begin
            for (int s = 0; s < 2; s++) begin
                wk_hit = 1'b0;
                wk_val = '0;
                for (int k = N_CDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && cdb_tag[k] == tag_q[i][s]) begin
                        wk_hit = 1'b1;
                        wk_val = cdb_value[k];
                    end
                end
                if (valid_q[i] && !rdy_q[i][s] && wk_hit) begin
                    rdy_d[i][s] = 1'b1;
                    val_d[i][s] = wk_val;
                end
            end
            if (issued[i]) begin
                for (int j = 0; j < N_ENT; j++) begin
                    age_d[i][j] = 1'b0;
                    age_d[j][i] = 1'b0;
                end
            end
        end
        // New entries are younger than every surviving entry; lane a is older than lane b.
        for (int l = 0; l < 2; l++) begin
            if (wr_lane[l]) begin
                valid_d[lane_idx[l]] = 1'b1;
                fu_d[lane_idx[l]]    = disp_fu[l];
                tag_d[lane_idx[l]]   = ln_tag[l];
                rdy_d[lane_idx[l]]   = ln_rdy[l];
                val_d[lane_idx[l]]   = ln_val[l];
                rob_d[lane_idx[l]]   = disp_rob[l];
                pay_d[lane_idx[l]]   = disp_payload[l];
                for (int j = 0; j < N_ENT; j++) begin
                    age_d[lane_idx[l]][j] = 1'b0;
                    age_d[j][lane_idx[l]] = valid_q[j] && !issued[j];
                end
                if (l == 1 && wr_lane[0])
                    age_d[lane_idx[0]][lane_idx[1]] = 1'b1;
            end
        end
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            fu_q          <= '0;
            tag_q         <= '0;
            rdy_q         <= '0;
            val_q         <= '0;
            rob_q         <= '0;
            pay_q         <= '0;
            age_q         <= '0;
            rs_overflow_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            fu_q          <= fu_d;
            tag_q         <= tag_d;
            rdy_q         <= rdy_d;
            val_q         <= val_d;
            rob_q         <= rob_d;
            pay_q         <= pay_d;
            age_q         <= age_d;
            rs_overflow_q <= rs_overflow_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: an age-ordered queue model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_rs_issue_queue;

    localparam int N_ENT = 16;

    logic                  clk = 1'b0;
    logic                  reset, flush;
    logic [1:0]            disp_valid;
    logic [1:0][1:0]       disp_fu;
    logic [1:0][5:0]       disp_src1_tag, disp_src2_tag;
    logic [1:0]            disp_src1_rdy, disp_src2_rdy;
    logic [1:0][31:0]      disp_src1_val, disp_src2_val;
    logic [1:0][3:0]       disp_rob;
    logic [1:0][63:0]      disp_payload;
    logic                  rs_stall, rs_overflow;
    logic [2:0]            cdb_valid;
    logic [2:0][5:0]       cdb_tag;
    logic [2:0][31:0]      cdb_value;
    logic [2:0]            fu_stall;
    logic [2:0]            iss_valid;
    logic [2:0][31:0]      iss_src1_val, iss_src2_val;
    logic [2:0][3:0]       iss_rob;
    logic [2:0][63:0]      iss_payload;

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_fu(disp_fu),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_rob(disp_rob), .disp_payload(disp_payload),
        .rs_stall(rs_stall), .rs_overflow(rs_overflow),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .fu_stall(fu_stall),
        .iss_valid(iss_valid), .iss_src1_val(iss_src1_val), .iss_src2_val(iss_src2_val),
        .iss_rob(iss_rob), .iss_payload(iss_payload)
    );

    typedef struct {
        logic [1:0]       fu;
        logic [1:0][5:0]  tag;
        logic [1:0]       rdy;
        logic [1:0][31:0] val;
        logic [3:0]       rob;
        logic [63:0]      pay;
    } ent_t;

    ent_t       mq[$];
    bit         m_ovf;
    bit         check_en = 1'b0;
    logic [2:0] exp_valid;
    int         exp_pos[3];
    int         tests = 0;
    int         fails = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Oldest ready entry per FU is simply the first matching one in age order.
    function automatic void modelSelect();
        exp_valid = '0;
        for (int f = 0; f < 3; f++) begin
            exp_pos[f] = -1;
            for (int p = 0; p < mq.size(); p++)
                if (exp_pos[f] < 0 && mq[p].fu == 2'(f) && mq[p].rdy == 2'b11)
                    exp_pos[f] = p;
            if (exp_pos[f] >= 0 && !fu_stall[f])
                exp_valid[f] = 1'b1;
        end
    endfunction

    function automatic logic [32:0] cdbLookup(input logic [5:0] tag);
        logic [32:0] r = '0;
        for (int k = 0; k < 3; k++)
            if (!r[32] && cdb_valid[k] && cdb_tag[k] == tag)
                r = {1'b1, cdb_value[k]};
        return r;
    endfunction

    task automatic modelStep();
        ent_t        nq[$];
        ent_t        e;
        bit          stall;
        bit          gone;
        logic [32:0] r;
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            check_en = 1'b1;
        end else if (check_en) begin
            modelSelect();
            stall = (N_ENT - mq.size()) < 2;
            for (int p = 0; p < mq.size(); p++) begin
                gone = 1'b0;
                for (int f = 0; f < 3; f++)
                    if (exp_valid[f] && exp_pos[f] == p) gone = 1'b1;
                if (!gone) begin
                    e = mq[p];
                    for (int s = 0; s < 2; s++) begin
                        r = cdbLookup(e.tag[s]);
                        if (!e.rdy[s] && r[32]) begin
                            e.rdy[s] = 1'b1;
                            e.val[s] = r[31:0];
                        end
                    end
                    nq.push_back(e);
                end
            end
            if (flush) begin
                nq.delete();
            end else if (disp_valid != 2'b00 && stall) begin
                m_ovf = 1'b1;
            end else begin
                for (int l = 0; l < 2; l++) begin
                    if (disp_valid[l]) begin
                        if (disp_fu[l] == 2'd3) begin
                            m_ovf = 1'b1;
                        end else begin
                            e.fu     = disp_fu[l];
                            e.tag[0] = disp_src1_tag[l];
                            e.tag[1] = disp_src2_tag[l];
                            e.rdy[0] = disp_src1_rdy[l];
                            e.rdy[1] = disp_src2_rdy[l];
                            e.val[0] = disp_src1_val[l];
                            e.val[1] = disp_src2_val[l];
                            e.rob    = disp_rob[l];
                            e.pay    = disp_payload[l];
                            for (int s = 0; s < 2; s++) begin
                                r = cdbLookup(e.tag[s]);
                                if (!e.rdy[s] && r[32]) begin
                                    e.rdy[s] = 1'b1;
                                    e.val[s] = r[31:0];
                                end
                            end
                            nq.push_back(e);
                        end
                    end
                end
            end
            mq = nq;
        end
    endtask

    task automatic compareAll();
        modelSelect();
        checkOutput("rs_stall", 64'(rs_stall), 64'(mq.size() > N_ENT - 2));
        checkOutput("rs_overflow", 64'(rs_overflow), 64'(m_ovf));
        checkOutput("iss_valid", 64'(iss_valid), 64'(exp_valid));
        for (int f = 0; f < 3; f++) begin
            checkOutput($sformatf("iss_src1_val[%0d]", f), 64'(iss_src1_val[f]),
                        exp_valid[f] ? 64'(mq[exp_pos[f]].val[0]) : 64'd0);
            checkOutput($sformatf("iss_src2_val[%0d]", f), 64'(iss_src2_val[f]),
                        exp_valid[f] ? 64'(mq[exp_pos[f]].val[1]) : 64'd0);
            checkOutput($sformatf("iss_rob[%0d]", f), 64'(iss_rob[f]),
                        exp_valid[f] ? 64'(mq[exp_pos[f]].rob) : 64'd0);
            checkOutput($sformatf("iss_payload[%0d]", f), iss_payload[f],
                        exp_valid[f] ? mq[exp_pos[f]].pay : 64'd0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (check_en) compareAll();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        flush         = 1'b0;
        disp_valid    = '0;
        disp_fu       = '0;
        disp_src1_tag = '0;
        disp_src2_tag = '0;
        disp_src1_rdy = '0;
        disp_src2_rdy = '0;
        disp_src1_val = '0;
        disp_src2_val = '0;
        disp_rob      = '0;
        disp_payload  = '0;
        cdb_valid     = '0;
        cdb_tag       = '0;
        cdb_value     = '0;
        fu_stall      = '0;
    endtask

    task automatic applyStimulus(input int lane, input logic [1:0] fu,
                                 input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                                 input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                                 input logic [3:0] rob);
        disp_valid[lane]    = 1'b1;
        disp_fu[lane]       = fu;
        disp_src1_tag[lane] = t1;
        disp_src1_rdy[lane] = r1;
        disp_src1_val[lane] = v1;
        disp_src2_tag[lane] = t2;
        disp_src2_rdy[lane] = r2;
        disp_src2_val[lane] = v2;
        disp_rob[lane]      = rob;
        disp_payload[lane]  = {rob, 4'(lane), 24'hA55A00, t1, 2'b00, t2, 2'b00, v1[15:0]};
    endtask

    task automatic setCdb(input int k, input logic [5:0] tag, input logic [31:0] value);
        cdb_valid[k] = 1'b1;
        cdb_tag[k]   = tag;
        cdb_value[k] = value;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_stall", 64'(rs_stall), 64'd0);
        checkOutput("reset_overflow", 64'(rs_overflow), 64'd0);
        checkOutput("reset_iss_valid", 64'(iss_valid), 64'd0);
        checkOutput("reset_iss_rob", 64'(iss_rob), 64'd0);

        // Ready ALU0 op issues one cycle after dispatch, then drains.
        applyStimulus(0, 2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 4'd2);
        #1 checkOutput("basic_same_cycle", 64'(iss_valid), 64'b000);
        tick(); clearInputs(); #1;
        checkOutput("basic_iss_valid", 64'(iss_valid), 64'b001);
        checkOutput("basic_src1", 64'(iss_src1_val[0]), 64'd5);
        checkOutput("basic_src2", 64'(iss_src2_val[0]), 64'd7);
        checkOutput("basic_rob", 64'(iss_rob[0]), 64'd2);
        tick(); #1 checkOutput("basic_drained", 64'(iss_valid), 64'b000);

        // CDB wakeup of an unready ALU1 source.
        applyStimulus(0, 2'd1, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'h11, 4'd5);
        tick(); clearInputs(); #1;
        checkOutput("wake_waiting", 64'(iss_valid), 64'b000);
        setCdb(0, 6'd12, 32'hDEAD);
        #1 checkOutput("wake_bcast_cycle", 64'(iss_valid), 64'b000);
        tick(); clearInputs(); #1;
        checkOutput("wake_iss_valid", 64'(iss_valid), 64'b010);
        checkOutput("wake_src1", 64'(iss_src1_val[1]), 64'hDEAD);
        checkOutput("wake_src2", 64'(iss_src2_val[1]), 64'h11);
        tick();

        // Same-cycle dispatch bypass.
        applyStimulus(0, 2'd0, 6'd4, 1'b1, 32'd1, 6'd9, 1'b0, 32'd0, 4'd6);
        setCdb(0, 6'd9, 32'h44);
        tick(); clearInputs(); #1;
        checkOutput("bypass_iss_valid", 64'(iss_valid), 64'b001);
        checkOutput("bypass_src2", 64'(iss_src2_val[0]), 64'h44);
        tick();

        // Two CDB ports carry the same tag: the lower port wins.
        applyStimulus(0, 2'd1, 6'd20, 1'b0, 32'd0, 6'd21, 1'b1, 32'd2, 4'd7);
        tick(); clearInputs();
        setCdb(1, 6'd20, 32'h111);
        setCdb(2, 6'd20, 32'h222);
        tick(); clearInputs(); #1;
        checkOutput("cdb_prio_src1", 64'(iss_src1_val[1]), 64'h111);
        tick();

        // Lane b alone.
        applyStimulus(1, 2'd2, 6'd5, 1'b1, 32'd8, 6'd6, 1'b1, 32'd9, 4'd8);
        tick(); clearInputs(); #1;
        checkOutput("lane_b_iss_valid", 64'(iss_valid), 64'b100);
        checkOutput("lane_b_rob", 64'(iss_rob[2]), 64'd8);
        tick();

        // MEM stalled two cycles, then strict age order.
        applyStimulus(0, 2'd2, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd3, 4'd3);
        applyStimulus(1, 2'd2, 6'd1, 1'b1, 32'd4, 6'd2, 1'b1, 32'd4, 4'd4);
        tick(); clearInputs();
        fu_stall = 3'b100;
        #1 checkOutput("fustall_c1", 64'(iss_valid), 64'b000);
        tick();
        #1 checkOutput("fustall_c2", 64'(iss_valid), 64'b000);
        tick(); fu_stall = 3'b000; #1;
        checkOutput("fustall_rel_rob3", 64'(iss_rob[2]), 64'd3);
        checkOutput("fustall_rel_valid", 64'(iss_valid), 64'b100);
        tick(); #1 checkOutput("fustall_next_rob4", 64'(iss_rob[2]), 64'd4);
        tick(); #1 checkOutput("fustall_empty", 64'(iss_valid), 64'b000);

        // Fill with unready MEM ops: 14 valid is not stalled, 15 is.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(0, 2'd2, 6'(40 + 2 * c), 1'b0, 32'd0, 6'd1, 1'b1, 32'(c), 4'(c));
            applyStimulus(1, 2'd2, 6'(41 + 2 * c), 1'b0, 32'd0, 6'd1, 1'b1, 32'(c + 16), 4'(c + 8));
            tick(); clearInputs();
        end
        #1 checkOutput("fill14_stall", 64'(rs_stall), 64'd0);
        applyStimulus(0, 2'd2, 6'd54, 1'b0, 32'd0, 6'd1, 1'b1, 32'd99, 4'd15);
        tick(); clearInputs(); #1;
        checkOutput("fill15_stall", 64'(rs_stall), 64'd1);
        applyStimulus(0, 2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 4'd10);
        tick(); clearInputs(); #1;
        checkOutput("overflow_set", 64'(rs_overflow), 64'd1);
        checkOutput("overflow_dropped", 64'(iss_valid), 64'b000);
        setCdb(0, 6'd40, 32'hAAAA);
        tick(); clearInputs(); #1;
        checkOutput("fill_wake_valid", 64'(iss_valid), 64'b100);
        checkOutput("fill_wake_src1", 64'(iss_src1_val[2]), 64'hAAAA);
        setCdb(0, 6'd41, 32'h41);
        setCdb(1, 6'd42, 32'h42);
        setCdb(2, 6'd43, 32'h43);
        for (int c = 0; c < 4; c++) begin
            tick(); clearInputs();
        end
        #1 checkOutput("overflow_sticky", 64'(rs_overflow), 64'd1);
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        checkOutput("reset2_overflow", 64'(rs_overflow), 64'd0);
        checkOutput("reset2_stall", 64'(rs_stall), 64'd0);

        // Flush with six waiting entries and a same-cycle dispatch.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 2'd0, 6'(30 + 2 * c), 1'b0, 32'd0, 6'd1, 1'b1, 32'd1, 4'(c));
            applyStimulus(1, 2'd1, 6'(31 + 2 * c), 1'b0, 32'd0, 6'd1, 1'b1, 32'd2, 4'(c + 4));
            tick(); clearInputs();
        end
        flush = 1'b1;
        applyStimulus(0, 2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 4'd9);
        tick(); clearInputs(); #1;
        checkOutput("flush_iss_valid", 64'(iss_valid), 64'b000);
        checkOutput("flush_stall", 64'(rs_stall), 64'd0);
        checkOutput("flush_overflow", 64'(rs_overflow), 64'd0);
        setCdb(0, 6'd30, 32'h1);
        setCdb(1, 6'd31, 32'h2);
        tick(); clearInputs(); #1;
        checkOutput("flush_no_ghost", 64'(iss_valid), 64'b000);

        // Illegal FU on lane a is dropped while lane b still dispatches.
        applyStimulus(0, 2'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 4'd11);
        applyStimulus(1, 2'd1, 6'd1, 1'b1, 32'd6, 6'd2, 1'b1, 32'd8, 4'd12);
        tick(); clearInputs(); #1;
        checkOutput("badfu_overflow", 64'(rs_overflow), 64'd1);
        checkOutput("badfu_lane_b", 64'(iss_valid), 64'b010);
        checkOutput("badfu_lane_b_rob", 64'(iss_rob[1]), 64'd12);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
